// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared widths and active-high segment patterns for the seg7 scan counter
package seg7_pkg;

    localparam int SEG_W      = 7;
    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 8;

    // Active-high patterns, bit 0 = segment a .. bit 6 = segment g
    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD digit to active-high 7-segment pattern
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [SEG_W-1:0] segments
);

    // Codes 10-15 never reach here from the counter, but are kept dark anyway
    always_comb begin
        segments = SEG_BLANK;
        case (digit)
            4'd0:    segments = SEG_0;
            4'd1:    segments = SEG_1;
            4'd2:    segments = SEG_2;
            4'd3:    segments = SEG_3;
            4'd4:    segments = SEG_4;
            4'd5:    segments = SEG_5;
            4'd6:    segments = SEG_6;
            4'd7:    segments = SEG_7;
            4'd8:    segments = SEG_8;
            4'd9:    segments = SEG_9;
            default: segments = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_counter.sv
// rtl/seg7_scan_counter.sv - N-digit BCD up/down counter with multiplexed 7-seg scan; optional LEADING_ZERO_BLANK_EN
module seg7_scan_counter
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int TICK_DIV       = 1125000,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    output logic [SEG_W-1:0]        seg,
    output logic [DIGITS-1:0]       an,
    output logic [BCD_W*DIGITS-1:0] bcd,
    output logic                    carry_out
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [TICK_W-1:0]       tick_cnt;
    logic [SCAN_W-1:0]       scan_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [BCD_W*DIGITS-1:0] bcd_step;
    logic [BCD_W*DIGITS-1:0] load_clean;
    logic [DIGITS:0]         chain;
    logic [DIGITS-1:0]       blank;
    logic [BCD_W-1:0]        cur_digit;
    logic [SEG_W-1:0]        dec_seg;
    logic [SEG_W-1:0]        seg_hi;
    logic [DIGITS-1:0]       an_hi;
    logic                    step;

    assign step = en && (tick_cnt == TICK_LAST);

    // Ripple carry/borrow through the digits; chain[DIGITS] set means the whole count wrapped
    always_comb begin
        bcd_step = bcd;
        chain    = '0;
        chain[0] = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (!chain[k]) begin
                bcd_step[k*BCD_W +: BCD_W] = bcd[k*BCD_W +: BCD_W];
                chain[k+1]                 = 1'b0;
            end else if (up_dn) begin
                if (bcd[k*BCD_W +: BCD_W] >= 4'd9) begin
                    bcd_step[k*BCD_W +: BCD_W] = 4'd0;
                    chain[k+1]                 = 1'b1;
                end else begin
                    bcd_step[k*BCD_W +: BCD_W] = bcd[k*BCD_W +: BCD_W] + 4'd1;
                    chain[k+1]                 = 1'b0;
                end
            end else begin
                if (bcd[k*BCD_W +: BCD_W] == 4'd0) begin
                    bcd_step[k*BCD_W +: BCD_W] = 4'd9;
                    chain[k+1]                 = 1'b1;
                end else begin
                    bcd_step[k*BCD_W +: BCD_W] = bcd[k*BCD_W +: BCD_W] - 4'd1;
                    chain[k+1]                 = 1'b0;
                end
            end
        end
    end

    // Non-BCD nibbles in a load are stored as zero so the chain never sees them
    always_comb begin
        load_clean = '0;
        for (int k = 0; k < DIGITS; k++) begin
            load_clean[k*BCD_W +: BCD_W] =
                (load_val[k*BCD_W +: BCD_W] > 4'd9) ? 4'd0 : load_val[k*BCD_W +: BCD_W];
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // zero_from[k]: digits k..DIGITS-1 are all zero; digit 0 is never blanked
    logic [DIGITS:0] zero_from;
    assign zero_from[DIGITS] = 1'b1;
    for (genvar k = 0; k < DIGITS; k++) begin : g_zero
        assign zero_from[k] = zero_from[k+1] && (bcd[k*BCD_W +: BCD_W] == 4'd0);
    end
    assign blank = zero_from[DIGITS-1:0] & ~DIGITS'(1);
`else
    assign blank = '0;
`endif

    assign cur_digit = bcd[digit_idx*BCD_W +: BCD_W];
    assign seg_hi    = blank[digit_idx] ? SEG_BLANK : dec_seg;
    assign an_hi     = DIGITS'(1) << digit_idx;

    seg7_decode u_decode (
        .digit    (cur_digit),
        .segments (dec_seg)
    );

    // Count divider and BCD register; load beats a coinciding step
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt  <= '0;
            bcd       <= '0;
            carry_out <= 1'b0;
        end else if (load) begin
            tick_cnt  <= '0;
            bcd       <= load_clean;
            carry_out <= 1'b0;
        end else begin
            carry_out <= 1'b0;
            if (step) begin
                tick_cnt  <= '0;
                bcd       <= bcd_step;
                carry_out <= chain[DIGITS];
            end else if (en) begin
                tick_cnt  <= tick_cnt + 1'b1;
            end
        end
    end

    // Scan divider runs regardless of en and walks the digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end else begin
            scan_cnt  <= scan_cnt + 1'b1;
        end
    end

    // Registered pin drive with polarity applied last
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_ACTIVE_LOW ? '1 : '0;
            an  <= SEG_ACTIVE_LOW ? '1 : '0;
        end else begin
            seg <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
            an  <= SEG_ACTIVE_LOW ? ~an_hi  : an_hi;
        end
    end

endmodule

// File: tb/tb_seg7_scan_counter.sv
// tb/tb_seg7_scan_counter.sv - scoreboard bench for seg7_scan_counter (DIGITS=4, TICK_DIV=4, SCAN_DIV=3)
module tb_seg7_scan_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        up_dn;
    logic        load;
    logic [15:0] load_val;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] bcd;
    logic        carry_out;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] bcd;
        logic        carry;
    } cnt_exp_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } disp_exp_t;

    cnt_exp_t  cnt_q[$];
    disp_exp_t disp_q[$];

    always #5 clk = ~clk;

    seg7_scan_counter #(
        .DIGITS         (4),
        .TICK_DIV       (4),
        .SCAN_DIV       (3),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up_dn     (up_dn),
        .load      (load),
        .load_val  (load_val),
        .seg       (seg),
        .an        (an),
        .bcd       (bcd),
        .carry_out (carry_out)
    );

    function automatic logic [6:0] seg_al(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0: p = 7'b0111111;
            4'd1: p = 7'b0000110;
            4'd2: p = 7'b1011011;
            4'd3: p = 7'b1001111;
            4'd4: p = 7'b1100110;
            4'd5: p = 7'b1101101;
            4'd6: p = 7'b1111101;
            4'd7: p = 7'b0000111;
            4'd8: p = 7'b1111111;
            4'd9: p = 7'b1101111;
            default: p = 7'b0000000;
        endcase
        return ~p;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int k);
        logic [3:0] d;
        d = v[k*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && (v >> (4*k)) == 16'h0) return 7'h7F;
`endif
        return seg_al(d);
    endfunction

    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_cnt(input logic [15:0] b, input logic c, input int n);
        cnt_exp_t e;
        e.bcd   = b;
        e.carry = c;
        for (int i = 0; i < n; i++) cnt_q.push_back(e);
    endtask

    // Display expectation for edge n after reset release; bcd_before is the count seen at that edge
    task automatic push_disp(input logic [15:0] bcd_before, input int n);
        disp_exp_t e;
        int        idx;
        idx   = ((n - 1) / 3) % 4;
        e.an  = ~(4'b0001 << idx);
        e.seg = exp_seg(bcd_before, idx);
        disp_q.push_back(e);
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 16'h0;
        cyc; cyc;
        checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd got=%h want=0000", bcd); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry got=%b want=0", carry_out); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h want=7f", seg); end
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got=%h want=f", an); end
        rst = 1'b0;
    endtask

    task automatic test_up_wrap;
        cnt_exp_t e;
        en = 1'b0; load = 1'b1; load_val = 16'h9999;
        cyc;
        load = 1'b0;
        checks++; if (bcd !== 16'h9999) begin errors++; $display("FAIL up_load got=%h want=9999", bcd); end
        en = 1'b1; up_dn = 1'b1;
        push_cnt(16'h9999, 1'b0, 3);
        push_cnt(16'h0000, 1'b1, 1);
        push_cnt(16'h0000, 1'b0, 3);
        push_cnt(16'h0001, 1'b0, 1);
        while (cnt_q.size() > 0) begin
            cyc;
            e = cnt_q.pop_front();
            checks++;
            if (bcd !== e.bcd || carry_out !== e.carry) begin
                errors++;
                $display("FAIL up_wrap got bcd=%h carry=%b want bcd=%h carry=%b", bcd, carry_out, e.bcd, e.carry);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_down_borrow;
        cnt_exp_t e;
        en = 1'b0; load = 1'b1; load_val = 16'h0100;
        cyc;
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        push_cnt(16'h0100, 1'b0, 3);
        push_cnt(16'h0099, 1'b0, 1);
        while (cnt_q.size() > 0) begin
            cyc;
            e = cnt_q.pop_front();
            checks++;
            if (bcd !== e.bcd || carry_out !== e.carry) begin
                errors++;
                $display("FAIL down_borrow got bcd=%h carry=%b want bcd=%h carry=%b", bcd, carry_out, e.bcd, e.carry);
            end
        end
        en = 1'b0; load = 1'b1; load_val = 16'h0000;
        cyc;
        load = 1'b0; en = 1'b1;
        push_cnt(16'h0000, 1'b0, 3);
        push_cnt(16'h9999, 1'b1, 1);
        push_cnt(16'h9999, 1'b0, 1);
        while (cnt_q.size() > 0) begin
            cyc;
            e = cnt_q.pop_front();
            checks++;
            if (bcd !== e.bcd || carry_out !== e.carry) begin
                errors++;
                $display("FAIL down_wrap got bcd=%h carry=%b want bcd=%h carry=%b", bcd, carry_out, e.bcd, e.carry);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_load_vs_step;
        cnt_exp_t e;
        en = 1'b0; up_dn = 1'b1; load = 1'b1; load_val = 16'h0005;
        cyc;
        load = 1'b0; en = 1'b1;
        push_cnt(16'h0005, 1'b0, 3);
        while (cnt_q.size() > 0) begin
            cyc;
            e = cnt_q.pop_front();
            checks++;
            if (bcd !== e.bcd || carry_out !== e.carry) begin
                errors++;
                $display("FAIL load_pre got bcd=%h carry=%b want bcd=%h carry=%b", bcd, carry_out, e.bcd, e.carry);
            end
        end
        // This edge is the step cycle; the load must win and sanitise the F nibble
        load = 1'b1; load_val = 16'h12F4;
        push_cnt(16'h1204, 1'b0, 1);
        cyc;
        load = 1'b0;
        e = cnt_q.pop_front();
        checks++;
        if (bcd !== e.bcd || carry_out !== e.carry) begin
            errors++;
            $display("FAIL load_step got bcd=%h carry=%b want bcd=%h carry=%b", bcd, carry_out, e.bcd, e.carry);
        end
        push_cnt(16'h1204, 1'b0, 3);
        push_cnt(16'h1205, 1'b0, 1);
        while (cnt_q.size() > 0) begin
            cyc;
            e = cnt_q.pop_front();
            checks++;
            if (bcd !== e.bcd || carry_out !== e.carry) begin
                errors++;
                $display("FAIL load_post got bcd=%h carry=%b want bcd=%h carry=%b", bcd, carry_out, e.bcd, e.carry);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_scan;
        disp_exp_t e;
        en = 1'b0; load = 1'b0; rst = 1'b1;
        cyc;
        rst = 1'b0; load = 1'b1; load_val = 16'h0080;
        push_disp(16'h0000, 1);
        for (int n = 2; n <= 15; n++) push_disp(16'h0080, n);
        for (int n = 1; n <= 15; n++) begin
            cyc;
            load = 1'b0;
            e = disp_q.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg) begin
                errors++;
                $display("FAIL scan n=%0d got an=%b seg=%h want an=%b seg=%h", n, an, seg, e.an, e.seg);
            end
        end
    endtask

    task automatic test_blank;
        disp_exp_t e;
        en = 1'b0; load = 1'b0; rst = 1'b1;
        cyc;
        rst = 1'b0; load = 1'b1; load_val = 16'h0007;
        push_disp(16'h0000, 1);
        for (int n = 2; n <= 12; n++) push_disp(16'h0007, n);
        for (int n = 1; n <= 12; n++) begin
            cyc;
            load = 1'b0;
            e = disp_q.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg) begin
                errors++;
                $display("FAIL blank n=%0d got an=%b seg=%h want an=%b seg=%h", n, an, seg, e.an, e.seg);
            end
        end
        checks++; if (bcd !== 16'h0007) begin errors++; $display("FAIL blank_bcd got=%h want=0007", bcd); end
    endtask

    task automatic test_reset_mid;
        en = 1'b0; load = 1'b1; load_val = 16'h1234;
        cyc;
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        cyc; cyc;
        rst = 1'b1; load = 1'b1; load_val = 16'h5678;
        cyc;
        checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL mid_reset_bcd got=%h want=0000", bcd); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL mid_reset_carry got=%b want=0", carry_out); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL mid_reset_seg got=%h want=7f", seg); end
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL mid_reset_an got=%h want=f", an); end
        rst = 1'b0; load = 1'b0;
        // Tick counter must also have cleared: four en cycles to the first step
        cyc; cyc; cyc;
        checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL mid_reset_tick got=%h want=0000", bcd); end
        cyc;
        checks++; if (bcd !== 16'h0001) begin errors++; $display("FAIL mid_reset_step got=%h want=0001", bcd); end
        en = 1'b0;
    endtask

    initial begin
        test_reset;
        test_up_wrap;
        test_down_borrow;
        test_load_vs_step;
        test_scan;
        test_blank;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
